sum_job_scheduler: RTL and testbench

Round-robin scheduler that shares a single accumulate-1-to-N datapath between NREQ requesters. Each requester submits a limit L and receives the sum 1+2+…+L over a valid/ready response channel, tagged with its requester ID. The block holds one job at a time. It owns the sequencing (load/enable/done) of an instantiated sum datapath.

---
 rtl/sum_sched_pkg.sv | 35 +++
 rtl/sum_datapath.sv | 38 +++
 rtl/sum_job_scheduler.sv | 105 ++++++++++
 tb/tb_sum_job_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_sched_pkg.sv
// Shared types and helpers for the round-robin sum job scheduler.
// Holds the FSM state encoding, default widths and the round-robin winner search.
package sum_sched_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefCw   = 8;
  localparam int unsigned DefSw   = 16;
  localparam int unsigned MaxReq  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCount,
    StResp
  } state_e;

  // First valid index searching upward from ptr+1 with wrap; 0 when nothing is valid.
  function automatic int unsigned rr_winner(input logic [MaxReq-1:0] valid,
                                            input int unsigned       ptr,
                                            input int unsigned       nreq);
    int unsigned idx;
    logic        found;
    rr_winner = 0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = ptr + k;
      if (idx >= nreq) idx = idx - nreq;
      if ((k <= nreq) && !found && valid[idx[4:0]]) begin
        rr_winner = idx;
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sum_datapath.sv
// Counter and accumulator computing 1+2+...+limit, sequenced by the scheduler.
// done compares the counter before it is incremented, so the final add lands on the done cycle.
module sum_datapath #(
  parameter int unsigned CW = 8,
  parameter int unsigned SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          done,
  output logic [SW-1:0] sum
);

  localparam logic [CW:0] CountOne = {{CW{1'b0}}, 1'b1};

  // One extra bit so a limit of 2^CW-1 can still be reached without wrapping.
  logic [CW:0]   count_q;
  logic [SW-1:0] sum_q;

  assign done = (count_q == {1'b0, limit});
  assign sum  = sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sum_q   <= '0;
    end else if (ld) begin
      count_q <= CountOne;
      sum_q   <= '0;
    end else if (en) begin
      count_q <= count_q + CountOne;
      sum_q   <= sum_q + SW'(count_q);
    end
  end

endmodule

// File: rtl/sum_job_scheduler.sv
// Round-robin scheduler sharing one sum datapath between NREQ requesters.
// Holds a single job at a time; results return over a valid/ready channel tagged with the id.
module sum_job_scheduler
  import sum_sched_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned CW   = DefCw,
  parameter int unsigned SW   = DefSw
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CW-1:0]       req_limit,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [SW-1:0]            rsp_sum,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     id_q;
  logic [IW-1:0]     winner;
  logic [CW-1:0]     limit_q;
  logic [MaxReq-1:0] valid_ext;
  logic              any_req;
  logic              accept;
  logic              dp_ld;
  logic              dp_en;
  logic              dp_done;

  assign valid_ext = MaxReq'(req_valid);
  assign any_req   = |req_valid;
  assign winner    = IW'(rr_winner(valid_ext, 32'(rr_ptr_q), NREQ));

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    dp_ld     = 1'b0;
    dp_en     = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The winner is always a valid requester, so a grant is also an accept.
        if (any_req) begin
          req_ready[winner] = 1'b1;
          accept            = 1'b1;
          state_d           = StLoad;
        end
      end
      StLoad: begin
        dp_ld   = 1'b1;
        state_d = (limit_q != '0) ? StCount : StResp;
      end
      StCount: begin
        dp_en = 1'b1;
        if (dp_done) state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= IW'(NREQ - 1);
      id_q     <= '0;
      limit_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        limit_q  <= req_limit[winner*CW +: CW];
        id_q     <= winner;
        rr_ptr_q <= winner;
      end
    end
  end

  assign rsp_id = id_q;
  assign busy   = (state_q != StIdle);

  // The accumulator register is idle during RESP, so it doubles as the held result.
  sum_datapath #(
    .CW(CW),
    .SW(SW)
  ) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .ld   (dp_ld),
    .en   (dp_en),
    .limit(limit_q),
    .done (dp_done),
    .sum  (rsp_sum)
  );

endmodule

// File: tb/tb_sum_job_scheduler.sv
// Self-checking bench for sum_job_scheduler: directed scenarios plus randomized jobs
// checked against a closed-form sum and a round-robin priority model.
module tb_sum_job_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int SW   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*CW-1:0] req_limit = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic [SW-1:0]     rsp_sum;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;
  int last_grant = NREQ - 1;
  int lims[NREQ];

  always #5 clk = ~clk;

  sum_job_scheduler #(
    .NREQ(NREQ),
    .CW  (CW),
    .SW  (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_limit(req_limit),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .busy     (busy)
  );

  function automatic logic [SW-1:0] tri_sum(input int l);
    return SW'((l * (l + 1)) / 2);
  endfunction

  function automatic int model_next(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int lim);
    req_valid[id]          = 1'b1;
    req_limit[id*CW +: CW] = lim[CW-1:0];
    lims[id]               = lim;
  endtask

  task automatic wait_grant(output int cycles);
    cycles = 0;
    #1;
    while (req_ready == '0 && cycles < 600) begin
      step();
      cycles++;
    end
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 600) begin
      step();
      cycles++;
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst        = 1'b0;
    last_grant = NREQ - 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_sum !== 16'd0) begin n_bad++; $display("FAIL reset_rsp_sum: got %0d want 0", rsp_sum); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int c;
    set_req(0, 100);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL basic_grant: got %b want 0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    wait_rsp(c);
    n_cmp++; if (c + 1 != 102) begin n_bad++; $display("FAIL basic_latency: got %0d want 102", c + 1); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL basic_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_sum !== tri_sum(100)) begin n_bad++; $display("FAIL basic_sum: got %0d want %0d", rsp_sum, tri_sum(100)); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    last_grant = 0;
  endtask

  task automatic test_zero_limit();
    int c;
    int g;
    set_req(2, 0);
    wait_grant(g);
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL zero_grant: got %b want 0100", req_ready); end
    step();
    req_valid[2] = 1'b0;
    wait_rsp(c);
    n_cmp++; if (c + 1 != 2) begin n_bad++; $display("FAIL zero_latency: got %0d want 2", c + 1); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL zero_id: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_sum !== 16'd0) begin n_bad++; $display("FAIL zero_sum: got %0d want 0", rsp_sum); end
    step();
    last_grant = 2;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] exp_vec;
    int c, g, exp_id, w;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1);
    pend = '1;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < NREQ; j++) begin
        wait_grant(g);
        exp_id  = model_next(pend, last_grant);
        exp_vec = '0;
        exp_vec[exp_id] = 1'b1;
        n_cmp++; if (req_ready !== exp_vec) begin n_bad++; $display("FAIL rr_grant: got %b want %b", req_ready, exp_vec); end
        n_cmp++; if (g != 0) begin n_bad++; $display("FAIL rr_grant_wait: got %0d want 0", g); end
        w = exp_id;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) w = i;
        step();
        req_valid[w] = 1'b0;
        pend[w]      = 1'b0;
        last_grant   = w;
        wait_rsp(c);
        n_cmp++; if (c + 1 != 2 + lims[exp_id]) begin n_bad++; $display("FAIL rr_latency: got %0d want %0d", c + 1, 2 + lims[exp_id]); end
        n_cmp++; if (rsp_id !== 2'(exp_id)) begin n_bad++; $display("FAIL rr_id: got %0d want %0d", rsp_id, exp_id); end
        n_cmp++; if (rsp_sum !== tri_sum(lims[exp_id])) begin n_bad++; $display("FAIL rr_sum: got %0d want %0d", rsp_sum, tri_sum(lims[exp_id])); end
        step();
      end
      for (int i = 0; i < NREQ; i++) set_req(i, int'($urandom_range(0, 20)));
      pend = (r == 0) ? '1 : '0;
      if (r != 0) req_valid = '0;
    end
  endtask

  task automatic test_stall();
    int c, g;
    rsp_ready = 1'b0;
    set_req(0, 5);
    wait_grant(g);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL stall_grant0: got %b want 0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    set_req(1, int'($urandom_range(1, 9)));
    wait_rsp(c);
    n_cmp++; if (c + 1 != 7) begin n_bad++; $display("FAIL stall_latency: got %0d want 7", c + 1); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", rsp_valid); end
      n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL stall_id: got %0d want 0", rsp_id); end
      n_cmp++; if (rsp_sum !== 16'd15) begin n_bad++; $display("FAIL stall_sum: got %0d want 15", rsp_sum); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_no_grant: got %b want 0000", req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_grant1: got %b want 0010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    wait_rsp(c);
    n_cmp++; if (rsp_sum !== tri_sum(lims[1])) begin n_bad++; $display("FAIL stall_sum1: got %0d want %0d", rsp_sum, tri_sum(lims[1])); end
    step();
    last_grant = 1;
  endtask

  task automatic test_reset_mid_job();
    int c, g, seen;
    set_req(2, 50);
    wait_grant(g);
    step();
    req_valid[2] = 1'b0;
    for (int k = 0; k < 20; k++) step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_sum !== 16'd0) begin n_bad++; $display("FAIL midrst_sum: got %0d want 0", rsp_sum); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL midrst_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", rsp_valid); end
    step();
    rst        = 1'b0;
    last_grant = NREQ - 1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) seen++;
      step();
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_no_rsp: got %0d want 0", seen); end
    set_req(3, 4);
    wait_grant(g);
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL midrst_grant3: got %b want 1000", req_ready); end
    step();
    req_valid[3] = 1'b0;
    wait_rsp(c);
    n_cmp++; if (c + 1 != 6) begin n_bad++; $display("FAIL midrst_latency: got %0d want 6", c + 1); end
    n_cmp++; if (rsp_id !== 2'd3) begin n_bad++; $display("FAIL midrst_id3: got %0d want 3", rsp_id); end
    n_cmp++; if (rsp_sum !== 16'd10) begin n_bad++; $display("FAIL midrst_sum3: got %0d want 10", rsp_sum); end
    step();
    last_grant = 3;
  endtask

  task automatic test_max_limit();
    int c, g;
    set_req(1, 255);
    wait_grant(g);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL max_grant: got %b want 0010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    wait_rsp(c);
    n_cmp++; if (c + 1 != 257) begin n_bad++; $display("FAIL max_latency: got %0d want 257", c + 1); end
    n_cmp++; if (rsp_sum !== 16'd32640) begin n_bad++; $display("FAIL max_sum: got %0d want 32640", rsp_sum); end
    n_cmp++; if (rsp_id !== 2'd1) begin n_bad++; $display("FAIL max_id: got %0d want 1", rsp_id); end
    step();
    last_grant = 1;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] exp_vec;
    int c, g, exp_id, w, stall;
    pend = '0;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, int'($urandom_range(0, 30)));
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        w = int'($urandom_range(0, NREQ - 1));
        set_req(w, int'($urandom_range(0, 30)));
        pend[w] = 1'b1;
      end
      wait_grant(g);
      exp_id  = model_next(pend, last_grant);
      exp_vec = '0;
      exp_vec[exp_id] = 1'b1;
      n_cmp++; if (req_ready !== exp_vec) begin n_bad++; $display("FAIL rand_grant: got %b want %b", req_ready, exp_vec); end
      w = exp_id;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) w = i;
      rsp_ready = 1'b0;
      step();
      req_valid[w] = 1'b0;
      pend[w]      = 1'b0;
      last_grant   = w;
      wait_rsp(c);
      n_cmp++; if (c + 1 != 2 + lims[exp_id]) begin n_bad++; $display("FAIL rand_latency: got %0d want %0d", c + 1, 2 + lims[exp_id]); end
      stall = int'($urandom_range(0, 3));
      for (int k = 0; k < stall; k++) step();
      n_cmp++; if (rsp_id !== 2'(exp_id)) begin n_bad++; $display("FAIL rand_id: got %0d want %0d", rsp_id, exp_id); end
      n_cmp++; if (rsp_sum !== tri_sum(lims[exp_id])) begin n_bad++; $display("FAIL rand_sum: got %0d want %0d", rsp_sum, tri_sum(lims[exp_id])); end
      rsp_ready = 1'b1;
      step();
    end
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_limit();
    test_round_robin();
    test_stall();
    test_reset_mid_job();
    test_max_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
